// File: rtl/psone_report_framer.sv
// Gamepad report framer: snapshots buttons/axes and streams a fixed frame to a UART.
// Optional macro PSONE_REPORT_CHECKSUM_EN appends an XOR checksum byte (6-byte frame).
module psone_report_framer #(
  parameter logic [23:0] PERIOD    = 24'd500000,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iENABLE,
  input  logic        iSEND_REQ,
  input  logic [15:0] iBTN,
  input  logic [7:0]  iAXIS_X,
  input  logic [7:0]  iAXIS_Y,
  output logic        oTRAN_ST,
  output logic [7:0]  oTX_BYTE,
  input  logic        iTRAN_BUSY,
  output logic        oFRAME_BUSY,
  output logic        oFRAME_DONE,
  output logic [7:0]  oFRAME_CNT
);

`ifdef PSONE_REPORT_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd5;
`else
  localparam logic [2:0] LAST_IDX = 3'd4;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_END
  } state_t;

  state_t      state_q;
  logic [23:0] period_q, period_d;
  logic        pending_q, pending_d;
  logic        periodHit;
  logic [2:0]  idx_q;
  logic [7:0]  btnLo_q, btnHi_q, axisX_q, axisY_q;
  logic [7:0]  curByte;
  logic        tranSt_q, frameBusy_q, frameDone_q;
  logic [7:0]  txByte_q, frameCnt_q;
`ifdef PSONE_REPORT_CHECKSUM_EN
  logic [7:0]  chk_q;
`endif

  // A request arriving in the same cycle IDLE consumes pending wins, so it is never lost.
  always_comb begin
    periodHit = iENABLE && (period_q == 24'd0);
    period_d  = period_q - 24'd1;
    if (!iENABLE || (period_q == 24'd0)) begin
      period_d = PERIOD - 24'd1;
    end
    pending_d = iSEND_REQ || periodHit || (pending_q && (state_q != S_IDLE));
    case (idx_q)
      3'd0:    curByte = SYNC_BYTE;
      3'd1:    curByte = btnLo_q;
      3'd2:    curByte = btnHi_q;
      3'd3:    curByte = axisX_q;
      3'd4:    curByte = axisY_q;
`ifdef PSONE_REPORT_CHECKSUM_EN
      default: curByte = chk_q;
`else
      default: curByte = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      period_q  <= PERIOD - 24'd1;
      pending_q <= 1'b0;
    end else begin
      period_q  <= period_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      btnLo_q     <= 8'h00;
      btnHi_q     <= 8'h00;
      axisX_q     <= 8'h00;
      axisY_q     <= 8'h00;
`ifdef PSONE_REPORT_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
      tranSt_q    <= 1'b0;
      txByte_q    <= 8'h00;
      frameBusy_q <= 1'b0;
      frameDone_q <= 1'b0;
      frameCnt_q  <= 8'h00;
    end else begin
      tranSt_q    <= 1'b0;
      frameDone_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_q) begin
            state_q     <= S_LOAD;
            frameBusy_q <= 1'b1;
          end
        end
        S_LOAD: begin
          btnLo_q <= iBTN[7:0];
          btnHi_q <= iBTN[15:8];
          axisX_q <= iAXIS_X;
          axisY_q <= iAXIS_Y;
`ifdef PSONE_REPORT_CHECKSUM_EN
          chk_q   <= iBTN[7:0] ^ iBTN[15:8] ^ iAXIS_X ^ iAXIS_Y;
`endif
          idx_q   <= 3'd0;
          state_q <= S_ISSUE;
        end
        // Strobe only when the UART is idle, so a UART busy out of reset is safe.
        S_ISSUE: begin
          if (!iTRAN_BUSY) begin
            tranSt_q <= 1'b1;
            txByte_q <= curByte;
            state_q  <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (iTRAN_BUSY) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (!iTRAN_BUSY) begin
            if (idx_q == LAST_IDX) begin
              state_q     <= S_END;
              frameBusy_q <= 1'b0;
              frameDone_q <= 1'b1;
              frameCnt_q  <= frameCnt_q + 8'd1;
            end else begin
              idx_q   <= idx_q + 3'd1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_END: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oTRAN_ST    = tranSt_q;
  assign oTX_BYTE    = txByte_q;
  assign oFRAME_BUSY = frameBusy_q;
  assign oFRAME_DONE = frameDone_q;
  assign oFRAME_CNT  = frameCnt_q;

endmodule
